rv_hart_scheduler: RTL and testbench

Parametrised hart scheduler for the RV cluster. It replaces the fixed "advance by one at every safe point" selector with quantum-based round-robin over N_HARTS cores, and adds three behaviours: skipping of non-runnable (WFI) harts, interrupt-driven preemption, and a drain/switch handshake with the shared interconnect/MMU. It sits between the cores and the cluster's shared memory path. It drives the hart-select index that steers all shared-port muxes, and the per-core stall mask.

---
 rtl/rv_sched_pkg.sv | 8 +
 rtl/rv_rr_pick.sv | 21 ++
 rtl/rv_hart_scheduler.sv | 90 +++++++++
 tb/tb_rv_hart_scheduler.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rv_sched_pkg.sv
// rv_sched_pkg: shared types and helpers for the hart scheduler
package rv_sched_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, SWITCH = 2'd2} state_t;
  localparam int DEFAULT_QUANTUM_C = 64;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rv_rr_pick.sv
// rv_rr_pick: first set mask bit scanning up from start+1 with wrap, start itself excluded
module rv_rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] start,
  output logic         valid,
  output logic [W-1:0] idx
);
  // scan from the far end so the hit nearest to start is written last
  always_comb begin
    valid = 1'b0;
    idx = start;
    for (int k = N - 1; k >= 1; k--)
      if (mask[(int'(start) + k) % N]) begin
        valid = 1'b1;
        idx = W'((int'(start) + k) % N);
      end
  end
endmodule

// File: rtl/rv_hart_scheduler.sv
// rv_hart_scheduler: quantum round-robin hart selector with irq preemption and drain/switch handshake
module rv_hart_scheduler
  import rv_sched_pkg::*;
#(
  parameter int N_HARTS = 2,
  parameter int QW = 8,
  parameter int DEFAULT_QUANTUM = DEFAULT_QUANTUM_C,
  localparam int HW = idx_w(N_HARTS)
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic               w_hold,
  input  logic [N_HARTS-1:0] w_boundary,
  input  logic [N_HARTS-1:0] w_retire,
  input  logic [N_HARTS-1:0] w_runnable,
  input  logic [N_HARTS-1:0] w_irq,
  input  logic               w_ic_idle,
  input  logic               w_cfg_we,
  input  logic [HW-1:0]      w_cfg_hart,
  input  logic [QW-1:0]      w_cfg_quantum,
  output logic [HW-1:0]      r_sel,
  output logic [N_HARTS-1:0] r_sel_oh,
  output logic [N_HARTS-1:0] r_core_stall,
  output logic               r_switch,
  output logic               r_idle
);
  state_t state, state_nx;
  logic [QW-1:0] quantum [N_HARTS];
  logic [QW-1:0] cnt;
  logic inf;
  logic [HW-1:0] target, cand, sel_nx, irq_idx, run_idx;
  logic irq_v, run_v, dec, expired, cand_v, reload;

  rv_rr_pick #(.N(N_HARTS), .W(HW)) u_irq_pick (
    .mask(w_irq & w_runnable), .start(r_sel), .valid(irq_v), .idx(irq_idx)
  );

  rv_rr_pick #(.N(N_HARTS), .W(HW)) u_run_pick (
    .mask(w_runnable), .start(r_sel), .valid(run_v), .idx(run_idx)
  );

  // switch decision and next state; inf marks a zero quantum loaded at the last reload
  always_comb begin
    dec = w_boundary[r_sel] && !w_hold;
    expired = cnt == '0 && !inf;
    cand_v = irq_v || ((expired || !w_runnable[r_sel]) && run_v);
    cand = irq_v ? irq_idx : run_idx;
    reload = state == RUN && dec && !cand_v && cnt == '0;
    state_nx = state == RUN ? (dec && cand_v ? DRAIN : RUN) :
               state == DRAIN ? (w_ic_idle ? SWITCH : DRAIN) : RUN;
    sel_nx = state == SWITCH ? target : r_sel;
  end

  // per-hart quantum registers; out-of-range targets are dropped
  always_ff @(posedge CLK or negedge RST_X)
    if (!RST_X)
      for (int i = 0; i < N_HARTS; i++) quantum[i] <= QW'(DEFAULT_QUANTUM);
    else if (w_cfg_we && int'(w_cfg_hart) < N_HARTS)
      quantum[w_cfg_hart] <= w_cfg_quantum;

  // state, quantum counter and registered outputs
  always_ff @(posedge CLK or negedge RST_X)
    if (!RST_X) begin
      state <= RUN;
      target <= '0;
      cnt <= QW'(DEFAULT_QUANTUM);
      inf <= DEFAULT_QUANTUM == 0;
      r_sel <= '0;
      r_sel_oh <= N_HARTS'(1);
      r_core_stall <= ~N_HARTS'(1);
      r_switch <= 1'b0;
      r_idle <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == RUN && dec && cand_v) target <= cand;
      if (state == SWITCH) begin
        cnt <= quantum[target];
        inf <= quantum[target] == '0;
      end else if (reload) begin
        cnt <= quantum[r_sel];
        inf <= quantum[r_sel] == '0;
      end else if (state == RUN && w_retire[r_sel] && cnt != '0 && !inf)
        cnt <= cnt - QW'(1);
      r_sel <= sel_nx;
      r_sel_oh <= N_HARTS'(1) << sel_nx;
      r_core_stall <= state_nx == RUN ? ~(N_HARTS'(1) << sel_nx) : '1;
      r_switch <= state == SWITCH;
      r_idle <= ~|w_runnable;
    end
endmodule

// File: tb/tb_rv_hart_scheduler.sv
// tb_rv_hart_scheduler: directed and random checks of rv_hart_scheduler against a behavioural model
module tb_rv_hart_scheduler;
  localparam int N = 3, QW = 8, DQ = 4, HW = 2;
  logic CLK = 1'b0, RST_X = 1'b0;
  logic w_hold, w_ic_idle, w_cfg_we, r_switch, r_idle;
  logic [N-1:0] w_boundary, w_retire, w_runnable, w_irq, r_sel_oh, r_core_stall;
  logic [HW-1:0] w_cfg_hart, r_sel;
  logic [QW-1:0] w_cfg_quantum;
  int total = 0, bad = 0;
  int ph, sel, cnt, tgt;
  int q [N];
  bit inf, e_sw, e_idle;
  logic [N-1:0] e_stall;

  rv_hart_scheduler #(.N_HARTS(N), .QW(QW), .DEFAULT_QUANTUM(DQ)) dut (
    .CLK(CLK), .RST_X(RST_X), .w_hold(w_hold), .w_boundary(w_boundary), .w_retire(w_retire),
    .w_runnable(w_runnable), .w_irq(w_irq), .w_ic_idle(w_ic_idle), .w_cfg_we(w_cfg_we),
    .w_cfg_hart(w_cfg_hart), .w_cfg_quantum(w_cfg_quantum), .r_sel(r_sel), .r_sel_oh(r_sel_oh),
    .r_core_stall(r_core_stall), .r_switch(r_switch), .r_idle(r_idle)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ph = 0; sel = 0; cnt = DQ; tgt = 0; inf = DQ == 0;
    foreach (q[i]) q[i] = DQ;
    e_sw = 0; e_idle = 0; e_stall = '1; e_stall[0] = 1'b0;
  endtask

  // one clock of the scheduling rules, evaluated on the inputs currently driven
  task automatic model_step();
    int c, oc, nph;
    c = -1; oc = cnt; nph = ph; e_sw = 0;
    if (ph == 0) begin
      if (w_retire[sel] && cnt > 0 && !inf) cnt = cnt - 1;
      if (w_boundary[sel] && !w_hold) begin
        for (int k = 1; k < N; k++)
          if (c < 0 && w_irq[(sel + k) % N] && w_runnable[(sel + k) % N]) c = (sel + k) % N;
        if (c < 0 && ((oc == 0 && !inf) || !w_runnable[sel]))
          for (int k = 1; k < N; k++)
            if (c < 0 && w_runnable[(sel + k) % N]) c = (sel + k) % N;
        if (c >= 0) begin
          nph = 1; tgt = c;
        end else if (oc == 0) begin
          cnt = q[sel]; inf = q[sel] == 0;
        end
      end
    end else if (ph == 1) begin
      if (w_ic_idle) nph = 2;
    end else begin
      nph = 0; sel = tgt; cnt = q[tgt]; inf = q[tgt] == 0; e_sw = 1;
    end
    ph = nph;
    if (w_cfg_we && int'(w_cfg_hart) < N) q[int'(w_cfg_hart)] = int'(w_cfg_quantum);
    for (int i = 0; i < N; i++) e_stall[i] = !(ph == 0 && i == sel);
    e_idle = w_runnable == '0;
  endtask

  task automatic check_all();
    chk("sel", 32'(r_sel), sel);
    chk("sel_oh", 32'(r_sel_oh), 1 << sel);
    chk("stall", 32'(r_core_stall), 32'(e_stall));
    chk("switch", 32'(r_switch), 32'(e_sw));
    chk("idle", 32'(r_idle), 32'(e_idle));
  endtask

  task automatic step();
    model_step();
    @(negedge CLK);
    check_all();
  endtask

  task automatic quiet();
    w_hold = 0; w_boundary = '0; w_retire = '0; w_runnable = '1; w_irq = '0;
    w_ic_idle = 1; w_cfg_we = 0; w_cfg_hart = '0; w_cfg_quantum = '0;
  endtask

  initial begin
    quiet();
    repeat (2) @(negedge CLK);
    chk("rst_sel", 32'(r_sel), 0);
    chk("rst_oh", 32'(r_sel_oh), 1);
    chk("rst_stall", 32'(r_core_stall), 3'b110);
    chk("rst_switch", 32'(r_switch), 0);
    chk("rst_idle", 32'(r_idle), 0);
    model_reset();
    RST_X = 1;
    // quantum expiry on hart 0 after four retires
    w_retire = 3'b001;
    repeat (4) step();
    w_retire = '0; w_boundary = 3'b001;
    step();
    chk("exp_drain", 32'(r_core_stall), 3'b111);
    quiet();
    step();
    chk("exp_hold_sel", 32'(r_sel), 0);
    step();
    chk("exp_sel", 32'(r_sel), 1);
    chk("exp_pulse", 32'(r_switch), 1);
    chk("exp_unstall", 32'(r_core_stall), 3'b101);
    step();
    chk("exp_pulse_end", 32'(r_switch), 0);
    // irq preemption with drain hold-off; a late irq must not retarget
    w_irq = 3'b100; w_boundary = 3'b010; w_ic_idle = 0;
    step();
    w_boundary = '0; w_irq = 3'b001;
    repeat (4) begin
      step();
      chk("hold_stall", 32'(r_core_stall), 3'b111);
      chk("hold_sel", 32'(r_sel), 1);
    end
    w_ic_idle = 1; w_irq = '0;
    step();
    step();
    chk("irq_sel", 32'(r_sel), 2);
    chk("irq_pulse", 32'(r_switch), 1);
    // reset in the middle of a drain
    w_irq = 3'b010; w_boundary = 3'b100; w_ic_idle = 0;
    step();
    quiet(); w_ic_idle = 0;
    #2 RST_X = 0;
    #1;
    chk("mid_rst_sel", 32'(r_sel), 0);
    chk("mid_rst_stall", 32'(r_core_stall), 3'b110);
    chk("mid_rst_switch", 32'(r_switch), 0);
    model_reset();
    @(negedge CLK);
    check_all();
    RST_X = 1;
    quiet();
    repeat (3) step();
    // zero quantum on hart 0, plus an ignored out-of-range write
    w_cfg_we = 1; w_cfg_hart = 2'd0; w_cfg_quantum = '0;
    step();
    w_cfg_hart = 2'd3; w_cfg_quantum = 8'd1;
    step();
    quiet(); w_retire = 3'b001;
    repeat (4) step();
    w_runnable = 3'b001; w_boundary = 3'b001;
    step();
    w_runnable = '1;
    repeat (10) begin
      step();
      chk("zq_stay", 32'(r_sel), 0);
    end
    w_retire = '0; w_irq = 3'b010;
    step();
    quiet();
    repeat (2) step();
    chk("zq_irq_sel", 32'(r_sel), 1);
    // randomized traffic against the model
    repeat (3000) begin
      w_boundary = N'($urandom);
      w_retire = N'($urandom);
      w_runnable = $urandom_range(0, 3) == 0 ? N'($urandom) : '1;
      w_irq = $urandom_range(0, 7) == 0 ? N'($urandom) : '0;
      w_hold = $urandom_range(0, 9) == 0;
      w_ic_idle = $urandom_range(0, 2) != 0;
      w_cfg_we = $urandom_range(0, 15) == 0;
      w_cfg_hart = HW'($urandom);
      w_cfg_quantum = QW'($urandom_range(0, 6));
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
